isq_scheduler: RTL and testbench

Collapsing, age-ordered issue queue scheduler between the rename/dispatch stage and the single ALU issue port. It accepts up to DISPATCH_WIDTH renamed ops per cycle and tracks per-operand readiness via physical-tag wakeup broadcasts. Each cycle it selects the oldest fully-ready entry and presents it to the ALU with a valid/ready handshake. It drives the `full` back-pressure that dispatch observes.

---
 rtl/isq_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_isq_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/isq_scheduler.sv
// Collapsing, age-ordered issue queue between rename/dispatch and one ALU port.
// Entries 0..count-1 are valid with index 0 the oldest; issue removes the
// oldest ready entry and shifts everything above it down by one slot.

package parameters;
    localparam int DISPATCH_WIDTH       = 2;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
endpackage

package common;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_cmd_t;
    typedef enum logic [1:0] {REG = 2'd0, IMM = 2'd1, PC = 2'd2} op_type_t;
endpackage

// Issue handshake: issue_valid and the payload are a function of registered
// state only; an entry leaves the queue on a clock edge where issue_valid and
// issue_ready are both high (unless flush/rst squashes that cycle).
module isq_scheduler #(
    parameter int ISQ_DEPTH            = 8,
    parameter int DISPATCH_WIDTH       = parameters::DISPATCH_WIDTH,
    parameter int WAKEUP_WIDTH         = 2,
    parameter int PHYS_REGS_ADDR_WIDTH = parameters::PHYS_REGS_ADDR_WIDTH,
    localparam int CMD_W = $bits(common::alu_cmd_t),
    localparam int TYP_W = $bits(common::op_type_t),
    localparam int CNT_W = $clog2(ISQ_DEPTH + 1),
    localparam int PW    = PHYS_REGS_ADDR_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [DISPATCH_WIDTH-1:0]             disp_en,
    input  logic [DISPATCH_WIDTH-1:0][CMD_W-1:0]  disp_alu_cmd,
    input  logic [DISPATCH_WIDTH-1:0]             disp_op1_valid,
    input  logic [DISPATCH_WIDTH-1:0]             disp_op2_valid,
    input  logic [DISPATCH_WIDTH-1:0][PW-1:0]     disp_op1,
    input  logic [DISPATCH_WIDTH-1:0][31:0]       disp_op2,
    input  logic [DISPATCH_WIDTH-1:0][TYP_W-1:0]  disp_op2_type,
    input  logic [DISPATCH_WIDTH-1:0][PW-1:0]     disp_phys_rd,
    output logic                                  full,
    input  logic [WAKEUP_WIDTH-1:0]               wakeup_valid,
    input  logic [WAKEUP_WIDTH-1:0][PW-1:0]       wakeup_tag,
    output logic                                  issue_valid,
    input  logic                                  issue_ready,
    output logic [CMD_W-1:0]                      issue_alu_cmd,
    output logic [PW-1:0]                         issue_op1,
    output logic [31:0]                           issue_op2,
    output logic [TYP_W-1:0]                      issue_op2_type,
    output logic [PW-1:0]                         issue_phys_rd,
    output logic [CNT_W-1:0]                      count
);
    localparam int IDX_W = (ISQ_DEPTH > 1) ? $clog2(ISQ_DEPTH) : 1;

    logic [CMD_W-1:0]     r_cmd      [ISQ_DEPTH];
    logic [PW-1:0]        r_op1      [ISQ_DEPTH];
    logic [31:0]          r_op2      [ISQ_DEPTH];
    logic [TYP_W-1:0]     r_op2_type [ISQ_DEPTH];
    logic [PW-1:0]        r_rd       [ISQ_DEPTH];
    logic [ISQ_DEPTH-1:0] r_op1_rdy;
    logic [ISQ_DEPTH-1:0] r_op2_rdy;
    logic [CNT_W-1:0]     r_count;

    logic [CMD_W-1:0]     w_n_cmd      [ISQ_DEPTH];
    logic [PW-1:0]        w_n_op1      [ISQ_DEPTH];
    logic [31:0]          w_n_op2      [ISQ_DEPTH];
    logic [TYP_W-1:0]     w_n_op2_type [ISQ_DEPTH];
    logic [PW-1:0]        w_n_rd       [ISQ_DEPTH];
    logic [ISQ_DEPTH-1:0] w_n_op1_rdy;
    logic [ISQ_DEPTH-1:0] w_n_op2_rdy;

    logic [ISQ_DEPTH-1:0]      w_entry_rdy, w_wake1, w_wake2;
    logic [DISPATCH_WIDTH-1:0] w_dwake1, w_dwake2, w_take;
    logic [CNT_W-1:0]          w_slot [DISPATCH_WIDTH];
    logic [CNT_W-1:0]          w_acc;
    logic [IDX_W-1:0]          w_sel;
    logic                      w_found, w_fire, w_full;

    // Tag match of every broadcast against stored and incoming operands.
    always_comb begin
        w_wake1  = '0;
        w_wake2  = '0;
        w_dwake1 = '0;
        w_dwake2 = '0;
        for (int k = 0; k < WAKEUP_WIDTH; k++) begin
            if (wakeup_valid[k]) begin
                for (int i = 0; i < ISQ_DEPTH; i++) begin
                    if (r_op1[i] == wakeup_tag[k]) w_wake1[i] = 1'b1;
                    if (r_op2_type[i] == common::REG && r_op2[i][PW-1:0] == wakeup_tag[k])
                        w_wake2[i] = 1'b1;
                end
                for (int l = 0; l < DISPATCH_WIDTH; l++) begin
                    if (disp_op1[l] == wakeup_tag[k]) w_dwake1[l] = 1'b1;
                    if (disp_op2_type[l] == common::REG && disp_op2[l][PW-1:0] == wakeup_tag[k])
                        w_dwake2[l] = 1'b1;
                end
            end
        end
    end

    // Oldest-ready select from registered ready bits; payload zero when idle.
    always_comb begin
        w_entry_rdy    = '0;
        w_found        = 1'b0;
        w_sel          = '0;
        issue_alu_cmd  = '0;
        issue_op1      = '0;
        issue_op2      = '0;
        issue_op2_type = '0;
        issue_phys_rd  = '0;
        for (int i = 0; i < ISQ_DEPTH; i++)
            w_entry_rdy[i] = (CNT_W'(i) < r_count) && r_op1_rdy[i] && r_op2_rdy[i];
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            if (!w_found && w_entry_rdy[i]) begin
                w_found        = 1'b1;
                w_sel          = IDX_W'(i);
                issue_alu_cmd  = r_cmd[i];
                issue_op1      = r_op1[i];
                issue_op2      = r_op2[i];
                issue_op2_type = r_op2_type[i];
                issue_phys_rd  = r_rd[i];
            end
        end
    end

    assign issue_valid = w_found;
    assign w_fire      = w_found & issue_ready;
    // Back-pressure looks only at the registered count, never at this cycle's issue.
    assign w_full      = (CNT_W'(ISQ_DEPTH) - r_count) < CNT_W'(DISPATCH_WIDTH);
    assign full        = w_full;
    assign count       = r_count;

    // Append slots: enabled lanes packed in lane order after the collapse.
    always_comb begin
        w_acc = r_count - CNT_W'(w_fire);
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            w_take[l] = disp_en[l] & ~w_full;
            w_slot[l] = w_acc;
            if (w_take[l]) w_acc = w_acc + CNT_W'(1);
        end
    end

    // Next entry contents: wakeup in place, collapse above the issued slot, append.
    always_comb begin
        w_n_cmd      = r_cmd;
        w_n_op1      = r_op1;
        w_n_op2      = r_op2;
        w_n_op2_type = r_op2_type;
        w_n_rd       = r_rd;
        w_n_op1_rdy  = r_op1_rdy | w_wake1;
        w_n_op2_rdy  = r_op2_rdy | w_wake2;
        if (w_fire) begin
            for (int i = 0; i < ISQ_DEPTH - 1; i++) begin
                if (IDX_W'(i) >= w_sel) begin
                    w_n_cmd[i]      = r_cmd[i+1];
                    w_n_op1[i]      = r_op1[i+1];
                    w_n_op2[i]      = r_op2[i+1];
                    w_n_op2_type[i] = r_op2_type[i+1];
                    w_n_rd[i]       = r_rd[i+1];
                    w_n_op1_rdy[i]  = r_op1_rdy[i+1] | w_wake1[i+1];
                    w_n_op2_rdy[i]  = r_op2_rdy[i+1] | w_wake2[i+1];
                end
            end
        end
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            for (int l = 0; l < DISPATCH_WIDTH; l++) begin
                if (w_take[l] && w_slot[l] == CNT_W'(i)) begin
                    w_n_cmd[i]      = disp_alu_cmd[l];
                    w_n_op1[i]      = disp_op1[l];
                    w_n_op2[i]      = disp_op2[l];
                    w_n_op2_type[i] = disp_op2_type[l];
                    w_n_rd[i]       = disp_phys_rd[l];
                    w_n_op1_rdy[i]  = disp_op1_valid[l] | w_dwake1[l];
                    // Immediates never wait on a tag.
                    w_n_op2_rdy[i]  = (disp_op2_type[l] != common::REG) |
                                      disp_op2_valid[l] | w_dwake2[l];
                end
            end
        end
    end

    // State register; rst and flush squash everything, including a same-cycle fire.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count   <= '0;
            r_op1_rdy <= '0;
            r_op2_rdy <= '0;
            for (int i = 0; i < ISQ_DEPTH; i++) begin
                r_cmd[i]      <= '0;
                r_op1[i]      <= '0;
                r_op2[i]      <= '0;
                r_op2_type[i] <= '0;
                r_rd[i]       <= '0;
            end
        end else begin
            r_count    <= w_acc;
            r_op1_rdy  <= w_n_op1_rdy;
            r_op2_rdy  <= w_n_op2_rdy;
            r_cmd      <= w_n_cmd;
            r_op1      <= w_n_op1;
            r_op2      <= w_n_op2;
            r_op2_type <= w_n_op2_type;
            r_rd       <= w_n_rd;
        end
    end

endmodule

// File: tb/tb_isq_scheduler.sv
// Directed bench for isq_scheduler: a vector table for single-cycle steps plus
// hand-written sequences for collapse order, op2 tag wakeup and flush.
module tb_isq_scheduler;

    logic             clk = 1'b0;
    logic             rst, flush;
    logic [1:0]       disp_en;
    logic [1:0][3:0]  disp_alu_cmd;
    logic [1:0]       disp_op1_valid, disp_op2_valid;
    logic [1:0][5:0]  disp_op1;
    logic [1:0][31:0] disp_op2;
    logic [1:0][1:0]  disp_op2_type;
    logic [1:0][5:0]  disp_phys_rd;
    logic             full;
    logic [1:0]       wakeup_valid;
    logic [1:0][5:0]  wakeup_tag;
    logic             issue_valid, issue_ready;
    logic [3:0]       issue_alu_cmd;
    logic [5:0]       issue_op1;
    logic [31:0]      issue_op2;
    logic [1:0]       issue_op2_type;
    logic [5:0]       issue_phys_rd;
    logic [3:0]       count;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] exp_q[$];
    logic       sb_en = 1'b0;

    isq_scheduler dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_en(disp_en), .disp_alu_cmd(disp_alu_cmd),
        .disp_op1_valid(disp_op1_valid), .disp_op2_valid(disp_op2_valid),
        .disp_op1(disp_op1), .disp_op2(disp_op2), .disp_op2_type(disp_op2_type),
        .disp_phys_rd(disp_phys_rd), .full(full),
        .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_alu_cmd(issue_alu_cmd), .issue_op1(issue_op1), .issue_op2(issue_op2),
        .issue_op2_type(issue_op2_type), .issue_phys_rd(issue_phys_rd), .count(count)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] en;
        logic [5:0] rd0, rd1, t0, t1;
        logic [1:0] v1;
        logic [1:0] wv;
        logic [5:0] wt0, wt1;
        logic       rdy, fl;
        logic       e_valid;
        logic [5:0] e_rd;
        logic [3:0] e_cnt;
        logic       e_full;
    } vec_t;

    vec_t vt[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Lanes carry immediates 0x100|rd with op2_valid=0 and alu_cmd=rd[3:0].
    task automatic set_in(input logic [1:0] en, input logic [5:0] rd0, input logic [5:0] rd1,
                          input logic [5:0] t0, input logic [5:0] t1, input logic [1:0] v1,
                          input logic [1:0] wv, input logic [5:0] wt0, input logic [5:0] wt1,
                          input logic rdy, input logic fl);
        disp_en          = en;
        disp_phys_rd[0]  = rd0;
        disp_phys_rd[1]  = rd1;
        disp_op1[0]      = t0;
        disp_op1[1]      = t1;
        disp_op1_valid   = v1;
        disp_op2_valid   = 2'b00;
        disp_op2[0]      = 32'h100 | {26'd0, rd0};
        disp_op2[1]      = 32'h100 | {26'd0, rd1};
        disp_op2_type[0] = 2'd1;
        disp_op2_type[1] = 2'd1;
        disp_alu_cmd[0]  = rd0[3:0];
        disp_alu_cmd[1]  = rd1[3:0];
        wakeup_valid     = wv;
        wakeup_tag[0]    = wt0;
        wakeup_tag[1]    = wt1;
        issue_ready      = rdy;
        flush            = fl;
    endtask

    task automatic idle();
        set_in(2'b00, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic e_valid, input logic [5:0] e_rd,
                               input logic [3:0] e_cnt, input logic e_full);
        check({tag, ".valid"}, {31'd0, issue_valid}, {31'd0, e_valid});
        check({tag, ".rd"},    {26'd0, issue_phys_rd}, {26'd0, e_rd});
        check({tag, ".count"}, {28'd0, count}, {28'd0, e_cnt});
        check({tag, ".full"},  {31'd0, full}, {31'd0, e_full});
    endtask

    // Scoreboard: every accepted issue (outside flush/reset) must match the expected order.
    always @(negedge clk) begin
        if (sb_en && !rst && !flush && issue_valid && issue_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_order: issued rd=%0d, expected no issue", issue_phys_rd);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                if (issue_phys_rd !== e) begin
                    n_errors++;
                    $display("FAIL sb_order: issued rd=%0d, want rd=%0d", issue_phys_rd, e);
                end
            end
        end
    end

    initial begin
        // en   rd0    rd1    t0     t1     v1     wv     wt0    wt1    rdy   fl  | valid rd  cnt full
        vt[0]  = '{2'b01, 6'd5,  6'd0,  6'd0, 6'd0,  2'b01, 2'b00, 6'd0,  6'd0,  1'b0, 1'b0, 1'b1, 6'd5,  4'd1, 1'b0};
        vt[1]  = '{2'b00, 6'd0,  6'd0,  6'd0, 6'd0,  2'b00, 2'b00, 6'd0,  6'd0,  1'b1, 1'b0, 1'b0, 6'd0,  4'd0, 1'b0};
        vt[2]  = '{2'b11, 6'd3,  6'd4,  6'd0, 6'd0,  2'b11, 2'b00, 6'd0,  6'd0,  1'b1, 1'b0, 1'b1, 6'd3,  4'd2, 1'b0};
        vt[3]  = '{2'b00, 6'd0,  6'd0,  6'd0, 6'd0,  2'b00, 2'b00, 6'd0,  6'd0,  1'b1, 1'b0, 1'b1, 6'd4,  4'd1, 1'b0};
        vt[4]  = '{2'b00, 6'd0,  6'd0,  6'd0, 6'd0,  2'b00, 2'b00, 6'd0,  6'd0,  1'b1, 1'b0, 1'b0, 6'd0,  4'd0, 1'b0};
        vt[5]  = '{2'b01, 6'd35, 6'd0,  6'd9, 6'd0,  2'b00, 2'b00, 6'd0,  6'd0,  1'b1, 1'b0, 1'b0, 6'd0,  4'd1, 1'b0};
        vt[6]  = '{2'b00, 6'd0,  6'd0,  6'd0, 6'd0,  2'b00, 2'b00, 6'd0,  6'd0,  1'b1, 1'b0, 1'b0, 6'd0,  4'd1, 1'b0};
        vt[7]  = '{2'b00, 6'd0,  6'd0,  6'd0, 6'd0,  2'b00, 2'b10, 6'd0,  6'd9,  1'b1, 1'b0, 1'b1, 6'd35, 4'd1, 1'b0};
        vt[8]  = '{2'b00, 6'd0,  6'd0,  6'd0, 6'd0,  2'b00, 2'b00, 6'd0,  6'd0,  1'b1, 1'b0, 1'b0, 6'd0,  4'd0, 1'b0};
        vt[9]  = '{2'b01, 6'd20, 6'd0,  6'd7, 6'd0,  2'b00, 2'b01, 6'd7,  6'd0,  1'b0, 1'b0, 1'b1, 6'd20, 4'd1, 1'b0};
        vt[10] = '{2'b00, 6'd0,  6'd0,  6'd0, 6'd0,  2'b00, 2'b00, 6'd0,  6'd0,  1'b1, 1'b0, 1'b0, 6'd0,  4'd0, 1'b0};
        vt[11] = '{2'b10, 6'd0,  6'd6,  6'd0, 6'd12, 2'b00, 2'b00, 6'd12, 6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  4'd1, 1'b0};
        vt[12] = '{2'b11, 6'd10, 6'd11, 6'd0, 6'd13, 2'b01, 2'b00, 6'd0,  6'd0,  1'b0, 1'b0, 1'b1, 6'd10, 4'd3, 1'b0};
        vt[13] = '{2'b00, 6'd0,  6'd0,  6'd0, 6'd0,  2'b00, 2'b11, 6'd13, 6'd12, 1'b0, 1'b0, 1'b1, 6'd6,  4'd3, 1'b0};
        vt[14] = '{2'b11, 6'd14, 6'd15, 6'd0, 6'd0,  2'b11, 2'b00, 6'd0,  6'd0,  1'b1, 1'b0, 1'b1, 6'd10, 4'd4, 1'b0};
        vt[15] = '{2'b11, 6'd16, 6'd17, 6'd0, 6'd0,  2'b11, 2'b00, 6'd0,  6'd0,  1'b0, 1'b0, 1'b1, 6'd10, 4'd6, 1'b0};
        vt[16] = '{2'b01, 6'd18, 6'd0,  6'd0, 6'd0,  2'b01, 2'b00, 6'd0,  6'd0,  1'b0, 1'b0, 1'b1, 6'd10, 4'd7, 1'b1};
        vt[17] = '{2'b11, 6'd40, 6'd41, 6'd0, 6'd0,  2'b11, 2'b00, 6'd0,  6'd0,  1'b0, 1'b0, 1'b1, 6'd10, 4'd7, 1'b1};
        vt[18] = '{2'b00, 6'd0,  6'd0,  6'd0, 6'd0,  2'b00, 2'b00, 6'd0,  6'd0,  1'b1, 1'b0, 1'b1, 6'd11, 4'd6, 1'b0};
        vt[19] = '{2'b01, 6'd42, 6'd0,  6'd0, 6'd0,  2'b01, 2'b00, 6'd0,  6'd0,  1'b1, 1'b1, 1'b0, 6'd0,  4'd0, 1'b0};

        // Reset
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_state("reset", 1'b0, 6'd0, 4'd0, 1'b0);
        check("reset.op2", issue_op2, 32'd0);
        check("reset.cmd", {28'd0, issue_alu_cmd}, 32'd0);
        check("reset.op1", {26'd0, issue_op1}, 32'd0);
        check("reset.type", {30'd0, issue_op2_type}, 32'd0);

        // Vector table
        for (int v = 0; v < 20; v++) begin
            set_in(vt[v].en, vt[v].rd0, vt[v].rd1, vt[v].t0, vt[v].t1, vt[v].v1,
                   vt[v].wv, vt[v].wt0, vt[v].wt1, vt[v].rdy, vt[v].fl);
            step();
            idle();
            check_state($sformatf("vec%0d", v), vt[v].e_valid, vt[v].e_rd, vt[v].e_cnt, vt[v].e_full);
            check($sformatf("vec%0d.op2", v), issue_op2,
                  vt[v].e_valid ? (32'h100 | {26'd0, vt[v].e_rd}) : 32'd0);
            check($sformatf("vec%0d.cmd", v), {28'd0, issue_alu_cmd},
                  vt[v].e_valid ? {28'd0, vt[v].e_rd[3:0]} : 32'd0);
            check($sformatf("vec%0d.type", v), {30'd0, issue_op2_type},
                  vt[v].e_valid ? 32'd1 : 32'd0);
        end

        // Collapse from the middle of a 7-entry queue, then drain in age order
        sb_en = 1'b1;
        exp_q.push_back(6'd52);
        exp_q.push_back(6'd50);
        exp_q.push_back(6'd51);
        exp_q.push_back(6'd53);
        exp_q.push_back(6'd54);
        exp_q.push_back(6'd55);
        exp_q.push_back(6'd56);
        set_in(2'b11, 6'd50, 6'd51, 6'd30, 6'd31, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        step();
        check_state("col.b1", 1'b0, 6'd0, 4'd2, 1'b0);
        set_in(2'b11, 6'd52, 6'd53, 6'd0, 6'd32, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        step();
        check_state("col.b2", 1'b1, 6'd52, 4'd4, 1'b0);
        set_in(2'b11, 6'd54, 6'd55, 6'd0, 6'd0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        step();
        check_state("col.b3", 1'b1, 6'd52, 4'd6, 1'b0);
        set_in(2'b01, 6'd56, 6'd0, 6'd0, 6'd0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        step();
        check_state("col.b4", 1'b1, 6'd52, 4'd7, 1'b1);
        set_in(2'b00, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
        step();
        check_state("col.fire2", 1'b1, 6'd54, 4'd6, 1'b0);
        set_in(2'b00, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00, 2'b01, 6'd32, 6'd0, 1'b0, 1'b0);
        step();
        check_state("col.wake32", 1'b1, 6'd53, 4'd6, 1'b0);
        set_in(2'b00, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00, 2'b11, 6'd30, 6'd31, 1'b0, 1'b0);
        step();
        check_state("col.wake30", 1'b1, 6'd50, 4'd6, 1'b0);
        for (int k = 0; k < 6; k++) begin
            set_in(2'b00, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
            step();
            check($sformatf("col.drain%0d.count", k), {28'd0, count}, 32'(5 - k));
        end
        idle();
        sb_en = 1'b0;
        check("col.sb_left", exp_q.size(), 32'd0);
        check_state("col.empty", 1'b0, 6'd0, 4'd0, 1'b0);

        // op2 register tag: waits for its own wakeup, not an unrelated one
        set_in(2'b01, 6'd22, 6'd0, 6'd1, 6'd0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        disp_op2_type[0] = 2'd0;
        disp_op2[0]      = 32'd21;
        step();
        idle();
        check_state("op2.wait", 1'b0, 6'd0, 4'd1, 1'b0);
        set_in(2'b00, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00, 2'b01, 6'd20, 6'd0, 1'b0, 1'b0);
        step();
        idle();
        check_state("op2.other", 1'b0, 6'd0, 4'd1, 1'b0);
        set_in(2'b00, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00, 2'b01, 6'd21, 6'd0, 1'b0, 1'b0);
        step();
        idle();
        check_state("op2.woken", 1'b1, 6'd22, 4'd1, 1'b0);
        check("op2.val", issue_op2, 32'd21);
        check("op2.op1", {26'd0, issue_op1}, 32'd1);
        check("op2.type", {30'd0, issue_op2_type}, 32'd0);
        set_in(2'b00, 6'd0, 6'd0, 6'd0, 6'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
        step();
        idle();
        check_state("op2.drain", 1'b0, 6'd0, 4'd0, 1'b0);

        // Flush with 5 entries plus same-cycle dispatch and fire
        set_in(2'b11, 6'd60, 6'd61, 6'd0, 6'd0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        step();
        set_in(2'b11, 6'd62, 6'd63, 6'd0, 6'd0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        step();
        set_in(2'b01, 6'd64, 6'd0, 6'd0, 6'd0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        step();
        check_state("fl.pre", 1'b1, 6'd60, 4'd5, 1'b0);
        set_in(2'b11, 6'd1, 6'd2, 6'd0, 6'd0, 2'b11, 2'b00, 6'd0, 6'd0, 1'b1, 1'b1);
        step();
        idle();
        check_state("fl.post", 1'b0, 6'd0, 4'd0, 1'b0);
        check("fl.op2", issue_op2, 32'd0);
        set_in(2'b01, 6'd9, 6'd0, 6'd0, 6'd0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
        step();
        idle();
        check_state("fl.reuse", 1'b1, 6'd9, 4'd1, 1'b0);

        // Mid-run reset clears the queue
        rst = 1'b1;
        set_in(2'b01, 6'd8, 6'd0, 6'd0, 6'd0, 2'b01, 2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
        step();
        idle();
        rst = 1'b0;
        check_state("rst.mid", 1'b0, 6'd0, 4'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
